// File: rtl/add64_serial_pkg.sv
// Shared ALU definitions used by the serial adder: word/digit widths, word type and FSM states.
package alu_pkg;
    localparam int WORD_W  = 64;
    localparam int DIGIT_W = 8;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE,
        RUN
    } add_state_t;
endpackage

// File: rtl/add64_serial_if.sv
// Request/result bundle of the serial adder; zf/sf exist only when ADD_CC_FLAGS_EN is defined.
interface add64_serial_if
    import alu_pkg::*;
    #(parameter int WIDTH = WORD_W) ();

    logic                    start;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic                    busy;
    logic                    done;
    logic        [WIDTH-1:0] result;
    logic                    carry_out;
    logic                    overflow;
`ifdef ADD_CC_FLAGS_EN
    logic                    zf;
    logic                    sf;
`endif

`ifdef ADD_CC_FLAGS_EN
    modport master (output start, a, b,
                    input  busy, done, result, carry_out, overflow, zf, sf);
    modport slave  (input  start, a, b,
                    output busy, done, result, carry_out, overflow, zf, sf);
`else
    modport master (output start, a, b,
                    input  busy, done, result, carry_out, overflow);
    modport slave  (input  start, a, b,
                    output busy, done, result, carry_out, overflow);
`endif
endinterface

// File: rtl/add64_serial_add_digit.sv
// Combinational DIGIT-bit adder slice with carry in/out, shared by every cycle of the serial add.
module add_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

// File: rtl/add64_serial.sv
// Multi-cycle adder: one DIGIT-bit slice per clock, result/carry/overflow registered with a done pulse.
// Optional macro ADD_CC_FLAGS_EN adds registered zero/sign flags.
module add64_serial
    import alu_pkg::*;
    #(
        parameter int WIDTH = WORD_W,
        parameter int DIGIT = DIGIT_W
    ) (
        input  logic           clk,
        input  logic           rst,
        add64_serial_if.slave  bus
    );

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    add_state_t        state_q;
    add_state_t        state_d;
    logic [IDX_W-1:0]  idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  result_next;
    logic              done_q;
    logic              carry_out_q;
    logic              overflow_q;
`ifdef ADD_CC_FLAGS_EN
    logic              zf_q;
    logic              sf_q;
`endif

    logic [DIGIT-1:0]  slice_a;
    logic [DIGIT-1:0]  slice_b;
    logic [DIGIT-1:0]  slice_sum;
    logic              slice_cout;
    logic              last_slice;

    add_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // The slice under work is picked from the latched operands; result_next merges it into the word.
    always_comb begin
        slice_a     = a_q[idx_q*DIGIT +: DIGIT];
        slice_b     = b_q[idx_q*DIGIT +: DIGIT];
        last_slice  = (idx_q == IDX_W'(NSLICE - 1));
        result_next = result_q;
        result_next[idx_q*DIGIT +: DIGIT] = slice_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_slice) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags are taken from the final slice directly so they land in the same cycle as the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef ADD_CC_FLAGS_EN
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        idx_q    <= '0;
                        carry_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                RUN: begin
                    result_q <= result_next;
                    carry_q  <= slice_cout;
                    idx_q    <= idx_q + 1'b1;
                    if (last_slice) begin
                        done_q      <= 1'b1;
                        carry_out_q <= slice_cout;
                        overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (slice_sum[DIGIT-1] != a_q[WIDTH-1]);
`ifdef ADD_CC_FLAGS_EN
                        zf_q        <= (result_next == '0);
                        sf_q        <= slice_sum[DIGIT-1];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
`ifdef ADD_CC_FLAGS_EN
    assign bus.zf        = zf_q;
    assign bus.sf        = sf_q;
`endif

endmodule

// File: tb/tb_add64_serial.sv
// Scoreboard bench for add64_serial: expected sums queued at start acceptance, checked on each done.
module tb_add64_serial;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        co;
        logic        ov;
        int          k;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks     = 0;
    int   errors     = 0;
    int   cycle      = 0;
    int   done_count = 0;
    exp_t sb[$];

    add64_serial_if bus ();

    add64_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int k);
        exp_t       e;
        logic [64:0] s;
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[63:0];
        e.co  = s[64];
        e.ov  = (a[63] == b[63]) && (s[63] != a[63]);
        e.k   = k;
        return e;
    endfunction

    // Every done pops one expectation; latency is measured from the accepting edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.done) begin
            done_count++;
            check_output("busy_with_done", 64'(bus.busy), 64'd0);
            if (sb.size() == 0) begin
                check_output("queue_on_done", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check_output("result", bus.result, e.res);
                check_output("carry_out", 64'(bus.carry_out), 64'(e.co));
                check_output("overflow", 64'(bus.overflow), 64'(e.ov));
                check_output("latency", 64'(cycle - e.k), 64'd8);
`ifdef ADD_CC_FLAGS_EN
                check_output("zf", 64'(bus.zf), 64'(e.res == 64'd0));
                check_output("sf", 64'(bus.sf), 64'(e.res[63]));
`endif
            end
        end
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        check_output({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_output({tag, "_done"}, 64'(bus.done), 64'd0);
        check_output({tag, "_result"}, bus.result, 64'd0);
        check_output({tag, "_carry"}, 64'(bus.carry_out), 64'd0);
        check_output({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
`ifdef ADD_CC_FLAGS_EN
        check_output({tag, "_zf"}, 64'(bus.zf), 64'd0);
        check_output({tag, "_sf"}, 64'(bus.sf), 64'd0);
`endif
    endtask

    task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e = model(a, b, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        sb.push_back(model(a, b, cycle));
        bus.start = 1'b0;
        bus.a     = {$urandom, $urandom};
        bus.b     = {$urandom, $urandom};
        @(negedge clk);
        check_output("busy_after_start", 64'(bus.busy), 64'd1);
        wait_done();
        repeat (2) @(negedge clk);
        check_output("result_hold", bus.result, e.res);
        check_output("idle_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin : stimulus
        int dc0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        apply_stimulus(64'd5, 64'd3);
        apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        apply_stimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus({$urandom, $urandom}, {$urandom, $urandom});
        end

        // start held through RUN with changing operands: one done, then back-to-back issue.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'd10;
        bus.b     = 64'd20;
        @(posedge clk);
        #1;
        sb.push_back(model(64'd10, 64'd20, cycle));
        bus.a = 64'd1;
        bus.b = 64'd1;
        dc0   = done_count;
        wait_done();
        @(posedge clk);
        #1;
        sb.push_back(model(64'd1, 64'd1, cycle));
        bus.start = 1'b0;
        check_output("single_done", 64'(done_count - dc0), 64'd1);
        wait_done();
        repeat (2) @(negedge clk);
        check_output("back_to_back_result", bus.result, 64'd2);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'h1111_1111_1111_1111;
        bus.b     = 64'h2222_2222_2222_2222;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_zero("midrun_rst");
        dc0 = done_count;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_output("no_done_after_rst", 64'(done_count), 64'(dc0));
        check_output("queue_empty", 64'(sb.size()), 64'd0);

        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("final_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        check_output("final_queue", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/add64_serial.md
# add64_serial

Multi-cycle 64-bit two's-complement adder for the Y-86 ALU: the additive counterpart to the combinational 64-bit subtractor.
- Operands are captured on a start handshake.
- The sum is produced one 8-bit digit per clock, trading latency for a short carry chain.
- Sum, carry-out and signed overflow are presented with a one-cycle done pulse.
- It sits beside the combinational add/sub units and is selected by the execute stage for `addq` when the multi-cycle path is configured.

## Interface
- `WIDTH`, 64, operand/result width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, 8, bits summed per cycle; number of slices `NSLICE = WIDTH/DIGIT` (8).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  signed operand A; captured when start is accepted.
- `b`  in  WIDTH  signed operand B; captured when start is accepted.
- `busy`  out  1  high while an operation is in progress (RUN).
- `done`  out  1  one-cycle pulse when `result` and flags become valid.
- `result`  out  WIDTH  a+b mod 2^WIDTH; held until the next accepted start.
- `carry_out`  out  1  unsigned carry from bit WIDTH-1.
- `overflow`  out  1  signed overflow.
- `zf`, `sf`  out  1 each  zero and sign flags; present only with `ADD_CC_FLAGS_EN`.

## Operation
- **FSM states:** IDLE, RUN.
- **IDLE, start=1:**
  - Latch `a` and `b`.
  - Clear the slice index, the carry register and `result`.
  - Go to RUN.
- **IDLE, start=0:** remain in IDLE; `result` and flags hold.
- **RUN:**
  - Slice index i selects bits [i·DIGIT +: DIGIT].
  - sum_i = a_i + b_i + carry; write into `result[i]`; carry ← bit DIGIT of sum_i.
  - i increments each cycle.
  - After slice NSLICE-1: `carry_out` ← final carry, compute `overflow`, pulse `done`, go to IDLE.
- **Overflow:** (a[63]==b[63]) && (result[63]!=a[63]), using the latched operands.
- **Operand capture:** operand changes on `a`/`b` after capture have no effect.
- **start during RUN:** ignored, not queued; the requester must wait for `done`.
- **rst at any time, including mid-RUN:**
  - State → IDLE; index → 0; carry → 0.
  - All outputs → 0; the in-flight operation is discarded, with no `done`.
- **Reset values:** `busy`=0, `done`=0, `result`=0, `carry_out`=0, `overflow`=0, `zf`=0, `sf`=0.

## Timing
- `start` is sampled at edge k in IDLE.
- `busy`=1 from after edge k.
- Slice i is written at edge k+1+i, for i=0..7.
- At edge k+8:
  - `busy`→0 and `done`→1 for exactly one cycle.
  - `result`, `carry_out` and `overflow` (and `zf`/`sf`) become valid at the same time.
- Latency start-to-done is 8 cycles.
- `start` held high during the done cycle is sampled at edge k+9, giving a minimum issue interval of 9 cycles.
- `done` and `busy` are never high together.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ADD_CC_FLAGS_EN`.
- **Defined:**
  - `zf` = (result==0) and `sf` = result[63] are registered at edge k+8 alongside `overflow`.
  - They reset to 0 and hold until the next `done`.
- **Undefined:**
  - The `zf`/`sf` ports and their logic are absent.
  - The condition-code unit derives flags externally.

## Structure
- **Shared package `alu_pkg`:**
  - `WORD_W`=64 and `DIGIT_W`=8.
  - FSM state enum `add_state_t {IDLE, RUN}`.
  - Typedef `word_t` (signed [63:0]).
- **Sub-module `add_digit`:**
  - Combinational DIGIT-bit ripple adder: a, b, cin → sum, cout.
  - It is instantiated once and reused every cycle.
  - The top level holds the FSM, index counter, operand and result registers, and flag logic.

## Test plan
- 5 + 3 → `result`=8, `carry_out`=0, `overflow`=0; `done` exactly 8 cycles after the start edge; `zf`=0, `sf`=0.
- 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000, `overflow`=1, `carry_out`=0, `sf`=1.
- 0xFFFF_FFFF_FFFF_FFFF + 1 → 0, `carry_out`=1, `overflow`=0, `zf`=1; checks carry ripple across all 8 slices.
- 0x8000_0000_0000_0000 + 0x8000_0000_0000_0000 → 0, `overflow`=1, `carry_out`=1.
- Start (10 + 20); hold `start` high and change operands to (1, 1) during RUN:
  - One `done` only, with `result`=30.
  - The next op, sampled in the cycle after `done`, gives 2.
- Assert `rst` at cycle 4 of RUN:
  - All outputs are 0 and there is no `done`.
  - A subsequent start of (−1) + (−1) → 0xFFFF_FFFF_FFFF_FFFE, `carry_out`=1, `overflow`=0.
